// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package tt_sweep_pkg;

    localparam int IDX_W   = 3;
    localparam int NUM_VEC = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/tt_sweep_ctrl_settle_timer.sv
// Settle countdown: load with SETTLE-1, count down while running, flag expiry at zero.
module tt_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expired
);
    localparam logic [3:0] LOAD_VAL = 4'(SETTLE - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (run && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Zero count marks the last settle cycle of the current vector.
    assign expired = (cnt_q == 4'd0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller for a 3-input combinational unit.
// Optional mismatch counter enabled by defining TT_SWEEP_ERRCNT_EN.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       dut_y,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] sig,
    output logic [3:0] err_cnt
);
    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       exp_q, exp_d;
    logic [7:0]       sig_q, sig_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [2:0]       abc_q, abc_d;
    logic             timer_load;
    logic             timer_expired;
`ifdef TT_SWEEP_ERRCNT_EN
    logic [3:0]       err_q, err_d;
`endif

    tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .run     (state_q == ST_SETTLE),
        .expired (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        exp_d      = exp_q;
        sig_d      = sig_q;
        pass_d     = pass_q;
        timer_load = 1'b0;
`ifdef TT_SWEEP_ERRCNT_EN
        err_d      = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Abort wins over a simultaneous start.
                if (start && !abort) begin
                    state_d    = ST_SETTLE;
                    exp_d      = expected;
                    sig_d      = 8'h00;
                    pass_d     = 1'b0;
                    idx_d      = '0;
                    timer_load = 1'b1;
`ifdef TT_SWEEP_ERRCNT_EN
                    err_d      = 4'd0;
`endif
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end else if (timer_expired) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    sig_d[idx_q] = dut_y;
`ifdef TT_SWEEP_ERRCNT_EN
                    if ((dut_y != exp_q[idx_q]) && (err_q != 4'd8)) begin
                        err_d = err_q + 4'd1;
                    end
`endif
                    if (idx_q == IDX_W'(NUM_VEC - 1)) begin
                        state_d = ST_DONE;
                        pass_d  = (sig_d == exp_q);
                    end else begin
                        state_d    = ST_SETTLE;
                        idx_d      = idx_q + 1'b1;
                        timer_load = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next-state view so they line up with the state.
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        abc_d  = busy_d ? idx_d : 3'b000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            exp_q   <= 8'h00;
            sig_q   <= 8'h00;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            abc_q   <= 3'b000;
`ifdef TT_SWEEP_ERRCNT_EN
            err_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            exp_q   <= exp_d;
            sig_q   <= sig_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            abc_q   <= abc_d;
`ifdef TT_SWEEP_ERRCNT_EN
            err_q   <= err_d;
`endif
        end
    end

    assign {dut_a, dut_b, dut_c} = abc_q;
    assign busy = busy_q;
    assign done = done_q;
    assign pass = pass_q;
    assign sig  = sig_q;
`ifdef TT_SWEEP_ERRCNT_EN
    assign err_cnt = err_q;
`else
    assign err_cnt = 4'd0;
`endif

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: SETTLE=1 and SETTLE=3 instances, directed and random sweeps.
module tb_tt_sweep_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       sel3;
    logic [7:0] expected;
    logic [7:0] fn;

    logic       a1, b1, c1, busy1, done1, pass1;
    logic [7:0] sig1;
    logic [3:0] err1;
    logic       a3, b3, c3, busy3, done3, pass3;
    logic [7:0] sig3;
    logic [3:0] err3;

    logic       busy_o, done_o, pass_o;
    logic [7:0] sig_o;
    logic [3:0] err_o;
    logic [2:0] abc_o;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    tt_sweep_ctrl #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel3), .abort(abort & ~sel3),
        .expected(expected), .dut_y(fn[{a1, b1, c1}]),
        .dut_a(a1), .dut_b(b1), .dut_c(c1), .busy(busy1), .done(done1),
        .pass(pass1), .sig(sig1), .err_cnt(err1)
    );

    tt_sweep_ctrl #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start & sel3), .abort(abort & sel3),
        .expected(expected), .dut_y(fn[{a3, b3, c3}]),
        .dut_a(a3), .dut_b(b3), .dut_c(c3), .busy(busy3), .done(done3),
        .pass(pass3), .sig(sig3), .err_cnt(err3)
    );

    assign busy_o = sel3 ? busy3 : busy1;
    assign done_o = sel3 ? done3 : done1;
    assign pass_o = sel3 ? pass3 : pass1;
    assign sig_o  = sel3 ? sig3  : sig1;
    assign err_o  = sel3 ? err3  : err1;
    assign abc_o  = sel3 ? {a3, b3, c3} : {a1, b1, c1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: number of truth-table entries that differ, when the counter is built in.
    function automatic logic [31:0] ref_err(input logic [7:0] got, input logic [7:0] gold);
`ifdef TT_SWEEP_ERRCNT_EN
        return 32'($countones(got ^ gold));
`else
        return 32'd0;
`endif
    endfunction

    task automatic sweep(input int s, input int pulse_at, input int abort_at, input bit chg,
                         output int cyc);
        int hold[8];
        int last;
        int order_err;
        for (int v = 0; v < 8; v++) hold[v] = 0;
        last = -1;
        order_err = 0;
        cyc = 0;
        start = 1'b1;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = (cyc == pulse_at);
            abort = (cyc == abort_at);
            if (chg && cyc == 1) expected = 8'h00;
            if (busy_o) begin
                hold[abc_o]++;
                if (int'(abc_o) != last) begin
                    if (int'(abc_o) != last + 1) order_err++;
                    last = int'(abc_o);
                end
            end
            if (done_o) break;
            if (abort_at != 0 && cyc == abort_at + 1) break;
        end
        start = 1'b0;
        abort = 1'b0;
        if (abort_at == 0) begin
            check("done_latency", cyc - 1, 8 * (s + 1));
            check("done_busy", busy_o, 0);
            check("done_abc", abc_o, 0);
            check("vec_order", order_err, 0);
            for (int v = 0; v < 8; v++) check("vec_hold", hold[v], s + 1);
        end
    endtask

    initial begin
        int cyc;
        logic [7:0] gold;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel3 = 1'b0;
        expected = 8'h00; fn = 8'hEA;
        repeat (2) @(negedge clk);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_pass", pass1, 0);
        check("rst_sig", sig1, 0);
        check("rst_err", err1, 0);
        check("rst_abc", {a1, b1, c1}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // y=(a&b)|c against its own table
        expected = 8'hEA;
        sweep(1, 0, 0, 0, cyc);
        check("t1_done", done_o, 1);
        check("t1_sig", sig_o, 8'hEA);
        check("t1_pass", pass_o, 1);
        check("t1_err", err_o, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t1_start_in_done", busy_o, 0);
        check("t1_done_pulse", done_o, 0);
        check("t1_pass_hold", pass_o, 1);
        check("t1_sig_hold", sig_o, 8'hEA);

        // one wrong golden bit
        expected = 8'hEB;
        sweep(1, 0, 0, 0, cyc);
        check("t2_sig", sig_o, 8'hEA);
        check("t2_pass", pass_o, 0);
        check("t2_err", err_o, ref_err(8'hEA, 8'hEB));
        @(negedge clk);

        // SETTLE=3 with start re-pulsed mid-sweep
        sel3 = 1'b1;
        expected = 8'hEA;
        sweep(3, 10, 0, 0, cyc);
        check("t3_sig", sig_o, 8'hEA);
        check("t3_pass", pass_o, 1);
        @(negedge clk);
        check("t3_idle", busy_o, 0);
        sel3 = 1'b0;

        // abort in cycle 5
        expected = ~fn;
        sweep(1, 0, 5, 0, cyc);
        check("t4_busy", busy_o, 0);
        check("t4_done", done_o, 0);
        check("t4_pass", pass_o, 0);
        check("t4_sig", sig_o, {6'b0, fn[1:0]});
        check("t4_err", err_o, ref_err({6'b0, fn[1:0]}, {6'b0, expected[1:0]}));
        @(negedge clk);
        check("t4_no_done", done_o, 0);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("t5_abort_prio", busy_o, 0);
        @(negedge clk);
        check("t5_abort_prio2", busy_o, 0);

        // reset between edges mid-sweep
        expected = 8'hEA;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy", busy1, 0);
        check("t6_done", done1, 0);
        check("t6_pass", pass1, 0);
        check("t6_sig", sig1, 0);
        check("t6_err", err1, 0);
        check("t6_abc", {a1, b1, c1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep(1, 0, 0, 0, cyc);
        check("t6_sig_after", sig_o, 8'hEA);
        check("t6_pass_after", pass_o, 1);
        @(negedge clk);

        // golden changed after start
        expected = 8'hEA;
        sweep(1, 0, 0, 1, cyc);
        check("t7_pass", pass_o, 1);
        check("t7_sig", sig_o, 8'hEA);
        @(negedge clk);

        // random functions and golden tables on both instances
        for (int k = 0; k < 8; k++) begin
            sel3 = (k % 4 == 3);
            fn = 8'($urandom);
            expected = ($urandom_range(0, 1) == 1) ? fn : 8'($urandom);
            gold = expected;
            sweep(sel3 ? 3 : 1, 0, 0, 0, cyc);
            check("rnd_sig", sig_o, fn);
            check("rnd_pass", pass_o, (fn == gold));
            check("rnd_err", err_o, ref_err(fn, gold));
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/tt_sweep_ctrl.md
TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning cycles each input vector is held before sampling (legal 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-005 SHALL have port abort  input  1  cancels a sweep in progress.
REQ-006 SHALL have port expected  input  8  golden truth table; bit i is the expected y for vector i = {a,b,c}.
REQ-007 SHALL have port dut_y  input  1  output of the 3-input combinational unit under test.
REQ-008 SHALL have ports dut_a, dut_b, dut_c  output  1 each  drive the unit's inputs.
REQ-009 SHALL have port busy  output  1  high while a sweep runs.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a sweep completes.
REQ-011 SHALL have port pass  output  1  high when sig equals the latched expected value.
REQ-012 SHALL have port sig  output  8  captured truth table; bit i is y sampled for vector i.
REQ-013 SHALL have port err_cnt  output  4  count of mismatching entries (see Configuration).

Function
REQ-014 SHALL implement states IDLE, SETTLE, SAMPLE and DONE.
REQ-015 SHALL, on start in IDLE, latch expected, clear sig/pass/err_cnt, set idx=0 and enter SETTLE on the next edge.
REQ-016 SHALL drive {dut_a,dut_b,dut_c} = idx[2:0] in SETTLE and SAMPLE, and 3'b000 in IDLE and DONE.
REQ-017 SHALL remain in SETTLE for exactly SETTLE cycles, then spend one cycle in SAMPLE, where it registers dut_y into sig[idx].
REQ-018 SHALL, leaving SAMPLE, go to DONE if idx==7, else increment idx and return to SETTLE; each vector therefore takes SETTLE+1 cycles, and a sweep takes 8*(SETTLE+1) cycles from the first SETTLE cycle to DONE.
REQ-019 SHALL assert done and a valid pass for exactly the single DONE cycle, then return to IDLE.
REQ-020 SHALL hold pass, sig and err_cnt after DONE until the next accepted start.
REQ-021 SHALL assert busy in SETTLE and SAMPLE only.
REQ-022 SHALL ignore start while not in IDLE, including during DONE.
REQ-023 SHALL, on abort in SETTLE or SAMPLE, enter IDLE on the next edge with no done pulse and pass=0, keeping the partial sig.
REQ-024 SHALL give abort priority when start and abort are high together in IDLE, so it stays in IDLE.
REQ-025 SHALL ignore changes on expected after it is latched.

Reset
REQ-026 SHALL, when rst_n is low, immediately force IDLE, idx=0, dut_a/b/c=0, busy=0, done=0, pass=0, sig=8'h00 and err_cnt=0, regardless of state.
REQ-027 SHALL accept no start until the first edge after rst_n deasserts.

Configuration
REQ-028 SHALL, with macro TT_SWEEP_ERRCNT_EN defined, increment err_cnt in every SAMPLE cycle where dut_y != expected[idx] (maximum 8, no wrap).
REQ-029 SHALL, without TT_SWEEP_ERRCNT_EN, tie err_cnt to 4'd0 and include no counter logic; all other behaviour is identical.

Structure
REQ-030 SHALL place the state encoding, idx width constant (3) and vector count constant (8) in shared package tt_sweep_pkg.
REQ-031 SHALL implement the settle countdown in one sub-module, tt_settle_timer (load SETTLE, count down, flag expiry).

Verification
REQ-032 SHALL test: SETTLE=1, DUT y=(a&b)|c, expected=8'hEA, start -> done after 16 cycles, sig=8'hEA, pass=1, err_cnt=0.
REQ-033 SHALL test: same DUT with expected=8'hEB -> pass=0, sig=8'hEA, err_cnt=1 with macro and 0 without.
REQ-034 SHALL test: SETTLE=3 with start re-pulsed mid-sweep -> pulse ignored, done exactly 32 cycles after the first SETTLE cycle, and each vector held 4 cycles.
REQ-035 SHALL test: abort in cycle 5 of a sweep -> busy=0 next cycle, no done pulse, pass=0, sig[1:0] captured.
REQ-036 SHALL test: rst_n low mid-sweep between edges -> all outputs 0 immediately, and a fresh start then gives a correct full sweep.
REQ-037 SHALL test: expected changed from 8'hEA to 8'h00 after start -> pass=1 still.
